// File: rtl/bisect_tuner.sv
// Bisection search of a current reference against an external measurement.
// The search holds an interval [a, b] of candidate currents. Each pass sets
// i_ref to the interval midpoint, requests a measurement, and narrows the
// interval toward the target. It stops on convergence, on a run of identical
// errors (no progress), or when the evaluation budget or interval runs out.
//
// state  | meaning
// IDLE   | waiting for start, i_ref held
// SET    | register midpoint into i_ref, issue meas_req
// WAIT   | waiting for meas_valid, capture q_measured
// EVAL   | compute error, pick a terminal status or narrow interval
// DONE   | search finished, status held, start may relaunch
module bisect_tuner #(
  parameter int WIDTH    = 10,
  parameter int TOL      = 1,
  parameter int MAX_ITER = 12,
  parameter int STALL_N  = 3,
  parameter int INVERT   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [WIDTH-1:0]              q_desired,
  input  logic                          meas_valid,
  input  logic [WIDTH-1:0]              q_measured,
  output logic [WIDTH-1:0]              i_ref,
  output logic                          meas_req,
  output logic                          busy,
  output logic                          done,
  output logic                          converged,
  output logic                          unstable,
  output logic                          timeout,
  output logic [$clog2(MAX_ITER+1)-1:0] iter_cnt
);

  localparam int IW = $clog2(MAX_ITER + 1);
  localparam int SW = $clog2(STALL_N + 1);
  localparam int EW = WIDTH + 1;
  localparam logic [WIDTH-1:0] B_INIT = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET,
    S_WAIT,
    S_EVAL,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  a_q, b_q, qd_q, meas_q, i_ref_q;
  logic [EW-1:0]     err_prev_q;
  logic [SW-1:0]     stall_q;
  logic [IW-1:0]     iter_q;
  logic              meas_req_q, busy_q, done_q;
  logic              converged_q, unstable_q, timeout_q;

  logic [EW-1:0]        sum_d;
  logic [WIDTH-1:0]     mid_d;
  logic [WIDTH-1:0]     span_d;
  logic signed [EW-1:0] diff_d;
  logic [EW-1:0]        err_d;
  logic [SW-1:0]        stall_d;
  logic [IW-1:0]        iter_d;
  logic                 raise_a_d;

  // Midpoint, error magnitude, stall run length and narrowing direction for EVAL/SET.
  always_comb begin
    sum_d  = {1'b0, a_q} + {1'b0, b_q};
    mid_d  = WIDTH'(sum_d >> 1);
    span_d = b_q - a_q;
    diff_d = $signed({1'b0, meas_q}) - $signed({1'b0, qd_q});
    err_d  = diff_d[EW-1] ? $unsigned(-diff_d) : $unsigned(diff_d);
    iter_d = iter_q + IW'(1);
    // The first evaluation of a search has no predecessor to compare against.
    if (iter_q == '0 || err_d != err_prev_q) begin
      stall_d = SW'(1);
    end else begin
      stall_d = stall_q + SW'(1);
    end
    // Measured value below target: need more q, which means more current
    // unless the plant response is inverted.
    raise_a_d = (meas_q < qd_q) ^ (INVERT != 0);
  end

  // Search controller with registered outputs; abort overrides every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= B_INIT;
      qd_q        <= '0;
      meas_q      <= '0;
      i_ref_q     <= '0;
      err_prev_q  <= '0;
      stall_q     <= '0;
      iter_q      <= '0;
      meas_req_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      converged_q <= 1'b0;
      unstable_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      meas_req_q <= 1'b0;
      done_q     <= 1'b0;
      if (abort) begin
        state_q     <= S_IDLE;
        busy_q      <= 1'b0;
        converged_q <= 1'b0;
        unstable_q  <= 1'b0;
        timeout_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (start) begin
              qd_q        <= q_desired;
              a_q         <= '0;
              b_q         <= B_INIT;
              iter_q      <= '0;
              stall_q     <= '0;
              err_prev_q  <= '0;
              converged_q <= 1'b0;
              unstable_q  <= 1'b0;
              timeout_q   <= 1'b0;
              busy_q      <= 1'b1;
              state_q     <= S_SET;
            end
          end
          S_SET: begin
            i_ref_q    <= mid_d;
            meas_req_q <= 1'b1;
            state_q    <= S_WAIT;
          end
          S_WAIT: begin
            if (meas_valid) begin
              meas_q  <= q_measured;
              state_q <= S_EVAL;
            end
          end
          S_EVAL: begin
            iter_q     <= iter_d;
            stall_q    <= stall_d;
            err_prev_q <= err_d;
            if (err_d <= EW'(TOL)) begin
              converged_q <= 1'b1;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= S_DONE;
            end else if (stall_d >= SW'(STALL_N)) begin
              unstable_q <= 1'b1;
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= S_DONE;
            end else if (iter_d >= IW'(MAX_ITER) || span_d <= WIDTH'(1)) begin
              timeout_q <= 1'b1;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= S_DONE;
            end else begin
              if (raise_a_d) begin
                a_q <= i_ref_q;
              end else begin
                b_q <= i_ref_q;
              end
              state_q <= S_SET;
            end
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign i_ref     = i_ref_q;
  assign meas_req  = meas_req_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign converged = converged_q;
  assign unstable  = unstable_q;
  assign timeout   = timeout_q;
  assign iter_cnt  = iter_q;

endmodule

// File: tb/tb_bisect_tuner.sv
// Bench for bisect_tuner: three instances (default, MAX_ITER=4, INVERT=1)
// driven one at a time by a behavioural plant, checked against a loop model
// of the bisection rules.
module tb_bisect_tuner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [9:0]  q_desired = '0;
  logic [1:0]  sel = 2'd0;
  logic        mv_plant = 1'b0, mv_man = 1'b0;
  logic [9:0]  qm_plant = '0, qm_man = '0;
  logic        mv;
  logic [9:0]  qm;
  logic [2:0]  start_w, mv_w;
  logic [9:0]  i_ref_w [3];
  logic [2:0]  req_w, busy_w, done_w, conv_w, unst_w, tmo_w;
  logic [3:0]  iter0, iter2;
  logic [2:0]  iter1;

  int n_cmp = 0;
  int n_fail = 0;
  bit plant_en = 0;
  int pmode = 0, poff = 0, plat = 0;

  assign mv      = mv_plant | mv_man;
  assign qm      = mv_man ? qm_man : qm_plant;
  assign start_w = {3{start}} & (3'b001 << sel);
  assign mv_w    = {3{mv}} & (3'b001 << sel);

  always #5 clk = ~clk;

  bisect_tuner dut0 (.clk(clk), .rst(rst), .start(start_w[0]), .abort(abort), .q_desired(q_desired),
    .meas_valid(mv_w[0]), .q_measured(qm), .i_ref(i_ref_w[0]), .meas_req(req_w[0]), .busy(busy_w[0]),
    .done(done_w[0]), .converged(conv_w[0]), .unstable(unst_w[0]), .timeout(tmo_w[0]), .iter_cnt(iter0));
  bisect_tuner #(.MAX_ITER(4)) dut1 (.clk(clk), .rst(rst), .start(start_w[1]), .abort(abort),
    .q_desired(q_desired), .meas_valid(mv_w[1]), .q_measured(qm), .i_ref(i_ref_w[1]), .meas_req(req_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .converged(conv_w[1]), .unstable(unst_w[1]), .timeout(tmo_w[1]),
    .iter_cnt(iter1));
  bisect_tuner #(.INVERT(1)) dut2 (.clk(clk), .rst(rst), .start(start_w[2]), .abort(abort),
    .q_desired(q_desired), .meas_valid(mv_w[2]), .q_measured(qm), .i_ref(i_ref_w[2]), .meas_req(req_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .converged(conv_w[2]), .unstable(unst_w[2]), .timeout(tmo_w[2]),
    .iter_cnt(iter2));

  function automatic int plant_q(int mode, int off, int i);
    int v;
    case (mode)
      0: v = i;
      1: v = 0;
      2: v = 1023 - i;
      default: begin
        v = i + off;
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
      end
    endcase
    return v;
  endfunction

  function automatic int iter_of(int k);
    if (k == 0) return int'(iter0);
    if (k == 1) return int'(iter1);
    return int'(iter2);
  endfunction

  // Reference: the bisection rules as a plain loop. ef: 1 converged, 2 unstable, 3 timeout.
  task automatic model(input int k, input int mode, input int off, input int qd,
                       output int ei, output int eit, output int ef);
    int a, b, prev, stall, maxit, i, q, err, n;
    bit inv;
    a = 0; b = 1023; prev = 0; stall = 0; n = 0; ef = 0; i = 0;
    maxit = (k == 1) ? 4 : 12;
    inv = (k == 2);
    while (ef == 0) begin
      i = (a + b) / 2;
      q = plant_q(mode, off, i);
      err = (q > qd) ? q - qd : qd - q;
      n++;
      stall = (n > 1 && err == prev) ? stall + 1 : 1;
      prev = err;
      if (err <= 1) ef = 1;
      else if (stall >= 3) ef = 2;
      else if (n >= maxit || b - a <= 1) ef = 3;
      else if ((q < qd) != inv) a = i;
      else b = i;
    end
    ei = i; eit = n;
  endtask

  // Plant: answers each meas_req after plat cycles with the plant response to i_ref.
  initial begin
    forever begin
      @(negedge clk);
      if (plant_en && req_w[sel]) begin
        repeat (plat) @(negedge clk);
        qm_plant = 10'(plant_q(pmode, poff, int'(i_ref_w[sel])));
        mv_plant = 1'b1;
        @(negedge clk);
        mv_plant = 1'b0;
      end
    end
  end

  task automatic run_search(input int k, input int mode, input int off, input int qd,
                            input int lat, input bit extra, input bit hold);
    int ei, eit, ef, cyc, n;
    bit seen_req;
    model(k, mode, off, qd, ei, eit, ef);
    n = eit;
    sel = 2'(k); pmode = mode; poff = off; plat = lat; plant_en = 1;
    @(negedge clk);
    q_desired = 10'(qd);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    seen_req = 0;
    n_cmp++;
    if (busy_w[k] !== 1'b1 || {conv_w[k], unst_w[k], tmo_w[k], done_w[k]} !== 4'b0 || iter_of(k) != 0) begin
      n_fail++;
      $display("FAIL start_state k=%0d: busy=%b flags=%b%b%b done=%b iter=%0d, required busy=1 flags/done=0 iter=0",
               k, busy_w[k], conv_w[k], unst_w[k], tmo_w[k], done_w[k], iter_of(k));
    end
    while (done_w[k] !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = extra && cyc == 3;
      if (extra && cyc == 3) q_desired = 10'($urandom);
      if (req_w[k] === 1'b1 && !seen_req) begin
        seen_req = 1;
        n_cmp++;
        if (i_ref_w[k] !== 10'd511) begin
          n_fail++;
          $display("FAIL first_i_ref k=%0d: got %0d required 511", k, i_ref_w[k]);
        end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (done_w[k] !== 1'b1) begin
      n_fail++;
      $display("FAIL done_wait k=%0d: no done within %0d cycles", k, cyc);
    end
    n_cmp++;
    if (cyc != 1 + n * (3 + lat)) begin
      n_fail++;
      $display("FAIL latency k=%0d: got %0d cycles required %0d", k, cyc, 1 + n * (3 + lat));
    end
    n_cmp++;
    if (int'(i_ref_w[k]) != ei || iter_of(k) != eit || busy_w[k] !== 1'b0 ||
        conv_w[k] !== (ef == 1) || unst_w[k] !== (ef == 2) || tmo_w[k] !== (ef == 3)) begin
      n_fail++;
      $display("FAIL result k=%0d qd=%0d mode=%0d: i_ref=%0d iter=%0d busy=%b c/u/t=%b%b%b, required i_ref=%0d iter=%0d busy=0 outcome=%0d",
               k, qd, mode, i_ref_w[k], iter_of(k), busy_w[k], conv_w[k], unst_w[k], tmo_w[k], ei, eit, ef);
    end
    if (hold) begin
      repeat (3) begin
        @(negedge clk);
        n_cmp++;
        if (done_w[k] !== 1'b0 || conv_w[k] !== (ef == 1) || unst_w[k] !== (ef == 2) ||
            tmo_w[k] !== (ef == 3) || int'(i_ref_w[k]) != ei) begin
          n_fail++;
          $display("FAIL done_hold k=%0d: done=%b c/u/t=%b%b%b i_ref=%0d, required done=0 outcome=%0d i_ref=%0d",
                   k, done_w[k], conv_w[k], unst_w[k], tmo_w[k], i_ref_w[k], ef, ei);
        end
      end
    end
    plant_en = 0;
  endtask

  task automatic test_reset();
    #2;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (i_ref_w[k] !== 10'd0 || {req_w[k], busy_w[k], done_w[k], conv_w[k], unst_w[k], tmo_w[k]} !== 6'b0 ||
          iter_of(k) != 0) begin
        n_fail++;
        $display("FAIL reset k=%0d: i_ref=%0d iter=%0d req/busy/done/c/u/t=%b%b%b%b%b%b, required all 0",
                 k, i_ref_w[k], iter_of(k), req_w[k], busy_w[k], done_w[k], conv_w[k], unst_w[k], tmo_w[k]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_linear();
    run_search(0, 0, 0, 300, 2, 0, 1);
    n_cmp++;
    if (conv_w[0] !== 1'b1 || i_ref_w[0] < 10'd299 || i_ref_w[0] > 10'd301 || iter0 > 4'd10) begin
      n_fail++;
      $display("FAIL linear_300: conv=%b i_ref=%0d iter=%0d, required conv=1 i_ref 299..301 iter<=10",
               conv_w[0], i_ref_w[0], iter0);
    end
  endtask

  task automatic test_stall();
    run_search(0, 1, 0, 500, 1, 0, 1);
    n_cmp++;
    if (unst_w[0] !== 1'b1 || conv_w[0] !== 1'b0 || iter0 !== 4'd3) begin
      n_fail++;
      $display("FAIL stall: unstable=%b conv=%b iter=%0d, required 1 0 3", unst_w[0], conv_w[0], iter0);
    end
  endtask

  task automatic test_max_iter();
    run_search(1, 0, 0, 1, 0, 0, 1);
    n_cmp++;
    if (tmo_w[1] !== 1'b1 || iter1 !== 3'd4 || i_ref_w[1] !== 10'd63) begin
      n_fail++;
      $display("FAIL max_iter: timeout=%b iter=%0d i_ref=%0d, required 1 4 63", tmo_w[1], iter1, i_ref_w[1]);
    end
  endtask

  task automatic test_invert();
    run_search(2, 2, 0, 200, 1, 0, 1);
    n_cmp++;
    if (conv_w[2] !== 1'b1 || i_ref_w[2] < 10'd822 || i_ref_w[2] > 10'd824) begin
      n_fail++;
      $display("FAIL invert: conv=%b i_ref=%0d, required conv=1 i_ref 822..824", conv_w[2], i_ref_w[2]);
    end
  endtask

  task automatic test_abort();
    int t;
    sel = 2'd0; plant_en = 0;
    @(negedge clk);
    q_desired = 10'd300; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (req_w[0] !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    abort = 1'b1; start = 1'b1; q_desired = 10'd5;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    n_cmp++;
    if (busy_w[0] !== 1'b0 || {done_w[0], conv_w[0], unst_w[0], tmo_w[0], req_w[0]} !== 5'b0 || i_ref_w[0] !== 10'd511) begin
      n_fail++;
      $display("FAIL abort: busy=%b done/c/u/t/req=%b%b%b%b%b i_ref=%0d, required all 0 and i_ref=511",
               busy_w[0], done_w[0], conv_w[0], unst_w[0], tmo_w[0], req_w[0], i_ref_w[0]);
    end
    qm_man = 10'd300; mv_man = 1'b1;
    @(negedge clk);
    mv_man = 1'b0;
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || req_w[0] !== 1'b0 || conv_w[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_idle: busy=%b done=%b req=%b conv=%b, required 0 0 0 0",
                 busy_w[0], done_w[0], req_w[0], conv_w[0]);
      end
    end
  endtask

  task automatic test_reset_eval();
    int t;
    sel = 2'd0; plant_en = 0;
    @(negedge clk);
    q_desired = 10'd400; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (req_w[0] !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    qm_man = 10'd100; mv_man = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (i_ref_w[0] !== 10'd0 || {req_w[0], busy_w[0], done_w[0], conv_w[0], unst_w[0], tmo_w[0]} !== 6'b0 || iter0 !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset: i_ref=%0d iter=%0d req/busy/done/c/u/t=%b%b%b%b%b%b, required all 0",
               i_ref_w[0], iter0, req_w[0], busy_w[0], done_w[0], conv_w[0], unst_w[0], tmo_w[0]);
    end
    #1 rst = 1'b0;
    mv_man = 1'b0;
    run_search(0, 0, 0, 700, 1, 0, 1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      run_search(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), int'($urandom_range(0, 200)) - 100,
                 int'($urandom_range(0, 1023)), int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      run_search(0, 0, 0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 2)), 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_stall();
    test_max_iter();
    test_invert();
    test_abort();
    test_reset_eval();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bisect_tuner.md
BISECT_TUNER -- requirements
Module: bisect_tuner

Interface
REQ-001 SHALL have parameter WIDTH, default 10, meaning data/current bus width.
REQ-002 SHALL have parameter TOL, default 1, meaning convergence tolerance on |q_measured - q_desired|.
REQ-003 SHALL have parameter MAX_ITER, default 12, meaning maximum evaluations per search.
REQ-004 SHALL have parameter STALL_N, default 3, meaning consecutive identical errors that flag instability.
REQ-005 SHALL have parameter INVERT, default 0, meaning 1 when q decreases as i_ref increases.
REQ-006 SHALL have: clk  input  1  clock, all logic on rising edge.
REQ-007 SHALL have: rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have: start  input  1  begin search, sampled in IDLE/DONE only.
REQ-009 SHALL have: abort  input  1  terminate search, return to IDLE.
REQ-010 SHALL have: q_desired  input  WIDTH  target, latched on accepted start.
REQ-011 SHALL have: meas_valid  input  1  q_measured valid this cycle.
REQ-012 SHALL have: q_measured  input  WIDTH  measurement result.
REQ-013 SHALL have: i_ref  output  WIDTH  registered current reference.
REQ-014 SHALL have: meas_req  output  1  one-cycle pulse requesting a measurement at current i_ref.
REQ-015 SHALL have: busy, done, converged, unstable, timeout  output  1 each  status.
REQ-016 SHALL have: iter_cnt  output  $clog2(MAX_ITER+1)  evaluations completed.

Function
REQ-017 SHALL implement FSM IDLE, SET, WAIT, EVAL, DONE; busy=1 in SET/WAIT/EVAL.
REQ-018 Accepted start SHALL latch q_desired, load a=0, b=2^WIDTH-1, iter_cnt=0, clear status flags and stall count, go to SET; start in SET/WAIT/EVAL SHALL be ignored.
REQ-019 SET SHALL register i_ref=(a+b)>>1 with the sum in WIDTH+1 bits (no overflow), pulse meas_req for exactly one cycle, go to WAIT.
REQ-020 WAIT SHALL hold until meas_valid=1, then capture q_measured and go to EVAL; meas_valid outside WAIT SHALL be ignored.
REQ-021 EVAL SHALL compute err=|q_measured - q_desired| as a WIDTH+1-bit signed difference, then absolute value, and increment iter_cnt.
REQ-022 EVAL priority: err<=TOL sets converged; else repeated-err count reaching STALL_N sets unstable; else iter_cnt reaching MAX_ITER or b-a<=1 sets timeout; each of these goes to DONE.
REQ-023 Otherwise, with INVERT=0: q_measured<q_desired sets a=i_ref, else b=i_ref; INVERT=1 swaps the two; go to SET.
REQ-024 The stall counter SHALL increment when err equals the previous EVAL's err and reset to 1 otherwise; it starts at 1 on the first EVAL.
REQ-025 done SHALL pulse one cycle on entry to DONE; converged/unstable/timeout SHALL be mutually exclusive and held until the next accepted start, abort or reset.
REQ-026 i_ref SHALL hold its last value in DONE and IDLE.
REQ-027 abort SHALL force IDLE on the next edge from any state, clear status flags, and suppress done; abort and start in the same cycle SHALL resolve to abort.
REQ-028 Total latency SHALL be 3 cycles plus measurement wait per iteration, plus 1 cycle to DONE.

Reset
REQ-029 rst SHALL force IDLE, i_ref=0, a=0, b=2^WIDTH-1, iter_cnt=0, meas_req=0, and all status outputs 0, immediately and regardless of clk.
REQ-030 rst asserted mid-search SHALL abandon the search; the first accepted start after release SHALL begin a fresh search.

Verification
REQ-031 Linear plant q=i_ref, q_desired=300, 2-cycle meas latency: converged=1, |i_ref-300|<=1, done pulses once, iter_cnt<=10.
REQ-032 Plant returns constant q=0 with q_desired=500: unstable=1 at iter_cnt=3, converged=0.
REQ-033 MAX_ITER=4, q_desired=1: timeout=1 at iter_cnt=4, i_ref=63.
REQ-034 INVERT=1, plant q=1023-i_ref, q_desired=200: converged with i_ref within 1 of 823.
REQ-035 abort asserted in WAIT together with start: IDLE next cycle, busy=0, no done, flags 0; later meas_valid ignored.
REQ-036 rst pulsed between clock edges during EVAL: outputs reach reset values asynchronously; the next start begins from i_ref=511.
